// File: rtl/fir_host_seq.sv
// Bus-side initiator for the FIR accelerator: programs length, taps and ap_start over AXI-Lite, streams N samples
// in and N results out concurrently, then polls ap_done. Stalls on any deasserted ready; one idle cycle between writes.
module fir_host_seq #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int POLL_MAX    = 1023
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready,
    input  logic                   cmd_start,
    input  logic [9:0]             cmd_len,
    output logic [3:0]             coef_idx,
    input  logic [pDATA_WIDTH-1:0] coef_in,
    output logic [9:0]             smp_idx,
    input  logic [pDATA_WIDTH-1:0] smp_in,
    output logic                   res_valid,
    output logic [pDATA_WIDTH-1:0] res_data,
    output logic [9:0]             res_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_LEN   = 3'd1;
    localparam logic [2:0] S_WR_TAP   = 3'd2;
    localparam logic [2:0] S_WR_START = 3'd3;
    localparam logic [2:0] S_STREAM   = 3'd4;
    localparam logic [2:0] S_POLL     = 3'd5;
    localparam logic [2:0] S_FINISH   = 3'd6;

    localparam int         PW       = $clog2(POLL_MAX + 1);
    localparam logic [3:0] LAST_TAP = 4'(Tape_Num - 1);

    logic [2:0]             state;
    logic [9:0]             len_r;
    logic [9:0]             in_cnt;
    logic [9:0]             out_cnt;
    logic [PW-1:0]          poll_cnt;
    logic                   wr_act;
    logic                   rd_act;
    logic                   run_err;
    logic [pADDR_WIDTH-1:0] wr_addr_nxt;
    logic [pDATA_WIDTH-1:0] wr_data_nxt;
    logic                   wr_cmpl;

    // sm_tlast and the upper status bits carry nothing this sequencer acts on
    logic unused_inputs;
    assign unused_inputs = sm_tlast ^ (^rdata);

    assign araddr    = '0;
    assign smp_idx   = in_cnt;
    assign ss_tvalid = (state == S_STREAM) && (in_cnt != len_r);
    assign ss_tdata  = ss_tvalid ? smp_in : '0;
    assign ss_tlast  = ss_tvalid && (in_cnt == len_r - 10'd1);
    assign sm_tready = (state == S_STREAM) && (out_cnt != len_r);

    // each channel may already have handshaken in an earlier cycle
    assign wr_cmpl = wr_act && (!awvalid || awready) && (!wvalid || wready);

    always_comb begin
        wr_addr_nxt = '0;
        wr_data_nxt = pDATA_WIDTH'(1);
        if (state == S_WR_LEN) begin
            wr_addr_nxt = pADDR_WIDTH'(16);
            wr_data_nxt = pDATA_WIDTH'(len_r);
        end else if (state == S_WR_TAP) begin
            wr_addr_nxt = pADDR_WIDTH'(32 + 4 * int'(coef_idx));
            wr_data_nxt = coef_in;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= S_IDLE;
            len_r     <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            poll_cnt  <= '0;
            wr_act    <= 1'b0;
            rd_act    <= 1'b0;
            run_err   <= 1'b0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            coef_idx  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        if (cmd_len != 10'd0) begin
                            len_r    <= cmd_len;
                            in_cnt   <= '0;
                            out_cnt  <= '0;
                            poll_cnt <= '0;
                            coef_idx <= '0;
                            busy     <= 1'b1;
                            state    <= S_WR_LEN;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                S_WR_LEN, S_WR_TAP, S_WR_START: begin
                    if (!wr_act) begin
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        awaddr  <= wr_addr_nxt;
                        wdata   <= wr_data_nxt;
                        wr_act  <= 1'b1;
                    end else begin
                        if (awvalid && awready) awvalid <= 1'b0;
                        if (wvalid && wready) wvalid <= 1'b0;
                        if (wr_cmpl) begin
                            wr_act <= 1'b0;
                            case (state)
                                S_WR_LEN: state <= S_WR_TAP;
                                S_WR_TAP: begin
                                    if (coef_idx == LAST_TAP) state <= S_WR_START;
                                    else coef_idx <= coef_idx + 4'd1;
                                end
                                default: state <= S_STREAM;
                            endcase
                        end
                    end
                end
                S_STREAM: begin
                    if (ss_tvalid && ss_tready) in_cnt <= in_cnt + 10'd1;
                    if (sm_tvalid && sm_tready) begin
                        res_valid <= 1'b1;
                        res_data  <= sm_tdata;
                        res_idx   <= out_cnt;
                        out_cnt   <= out_cnt + 10'd1;
                    end
                    if (in_cnt == len_r && out_cnt == len_r) state <= S_POLL;
                end
                S_POLL: begin
                    if (!rd_act) begin
                        arvalid <= 1'b1;
                        rd_act  <= 1'b1;
                    end else if (arvalid) begin
                        if (arready) begin
                            arvalid <= 1'b0;
                            rready  <= 1'b1;
                        end
                    end else if (rvalid && rready) begin
                        rready   <= 1'b0;
                        rd_act   <= 1'b0;
                        poll_cnt <= poll_cnt + 1'b1;
                        // ap_done wins even on the final permitted read
                        if (rdata[1]) begin
                            run_err <= 1'b0;
                            state   <= S_FINISH;
                        end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                            run_err <= 1'b1;
                            state   <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    err   <= run_err;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_host_seq.sv
// Directed bench for fir_host_seq: AXI-Lite slave, stream sink/source and poll responder modelled in the bench.
module tb_fir_host_seq;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int PM = 6;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata, ss_tdata, sm_tdata, coef_in, smp_in, res_data;
    logic          ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tlast, sm_tready;
    logic          cmd_start, res_valid, busy, done, err;
    logic [9:0]    cmd_len, smp_idx, res_idx;
    logic [3:0]    coef_idx;

    always #5 axis_clk = ~axis_clk;

    fir_host_seq #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11), .POLL_MAX(PM)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .cmd_start(cmd_start), .cmd_len(cmd_len),
        .coef_idx(coef_idx), .coef_in(coef_in), .smp_idx(smp_idx), .smp_in(smp_in),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done), .err(err)
    );

    // bench-side environment knobs
    int   aw_delay = 0, sm_limit = 0, done_on_read = 1, exp_n = 0;
    logic ss_toggle = 1'b0, sm_bursty = 1'b0, tb_clr = 1'b1;
    int   aw_cnt = 0, sm_sent = 0, rd_cnt = 0, cyc = 0;
    logic ss_ph = 1'b0;

    assign awready   = awvalid && (aw_cnt >= aw_delay);
    assign wready    = 1'b1;
    assign arready   = 1'b1;
    assign ss_tready = ss_toggle ? ss_ph : 1'b1;
    assign sm_tvalid = (sm_sent < sm_limit) && (!sm_bursty || ((cyc % 7) < 4));
    assign sm_tdata  = 32'h5000_0000 + sm_sent;
    assign sm_tlast  = sm_tvalid && (sm_sent == sm_limit - 1);
    assign coef_in   = 32'h0000_C000 + 32'(coef_idx) * 17;
    assign smp_in    = 32'hA000_0000 + 32'(smp_idx) * 3;

    always @(posedge axis_clk) begin
        cyc   <= cyc + 1;
        ss_ph <= ~ss_ph;
        if (tb_clr || !axis_rst_n) begin
            aw_cnt  <= 0;
            sm_sent <= 0;
            rd_cnt  <= 0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            if (awvalid && awready) aw_cnt <= 0;
            else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (sm_tvalid && sm_tready) sm_sent <= sm_sent + 1;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rd_cnt <= rd_cnt + 1;
                rdata  <= (rd_cnt + 1 >= done_on_read) ? 32'h2 : 32'h4;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // observers
    logic [31:0] aw_q[$], w_q[$];
    int   ar_n, ss_n, tlast_n, sm_acc, res_n, done_n, ss_err, res_err, order_err, stab_err;
    logic p_awv = 1'b0, p_wv = 1'b0, p_awhs = 1'b0, p_whs = 1'b0;
    logic [AW-1:0] p_awaddr = '0;
    logic [DW-1:0] p_wdata = '0;

    always @(negedge axis_clk) begin
        if (tb_clr) begin
            aw_q.delete();
            w_q.delete();
            ar_n <= 0; ss_n <= 0; tlast_n <= 0; sm_acc <= 0; res_n <= 0; done_n <= 0;
            ss_err <= 0; res_err <= 0; order_err <= 0; stab_err <= 0;
        end else begin
            if (((awvalid && !p_awv) || (wvalid && !p_wv)) && (aw_q.size() != w_q.size()))
                order_err <= order_err + 1;
            if ((awvalid && p_awv && !p_awhs && awaddr !== p_awaddr) ||
                (wvalid && p_wv && !p_whs && wdata !== p_wdata))
                stab_err <= stab_err + 1;
            if (awvalid && awready) aw_q.push_back(32'(awaddr));
            if (wvalid && wready) w_q.push_back(wdata);
            if (arvalid && arready) ar_n <= ar_n + 1;
            if (ss_tvalid && ss_tready) begin
                if (ss_tdata !== 32'hA000_0000 + 32'(ss_n) * 3 || smp_idx !== 10'(ss_n) ||
                    ss_tlast !== (ss_n == exp_n - 1))
                    ss_err <= ss_err + 1;
                if (ss_tlast) tlast_n <= tlast_n + 1;
                ss_n <= ss_n + 1;
            end
            if (sm_tvalid && sm_tready) sm_acc <= sm_acc + 1;
            if (res_valid) begin
                if (res_idx !== 10'(res_n) || res_data !== 32'h5000_0000 + 32'(res_n))
                    res_err <= res_err + 1;
                res_n <= res_n + 1;
            end
            if (done) done_n <= done_n + 1;
        end
        p_awv    <= awvalid;
        p_wv     <= wvalid;
        p_awhs   <= awvalid && awready;
        p_whs    <= wvalid && wready;
        p_awaddr <= awaddr;
        p_wdata  <= wdata;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clr(input int n, input int lim);
        @(posedge axis_clk); #1;
        tb_clr = 1'b1; exp_n = n; sm_limit = lim;
        @(posedge axis_clk); #1;
        tb_clr = 1'b0;
    endtask

    task automatic start(input logic [9:0] n);
        @(posedge axis_clk); #1;
        cmd_len = n; cmd_start = 1'b1;
        @(posedge axis_clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic exp_err);
        logic got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge axis_clk);
            if (done) got = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(got), 1);
        if (got) begin
            chk({tag, "_err"}, 32'(err), 32'(exp_err));
            chk({tag, "_busy_low"}, 32'(busy), 0);
        end
    endtask

    task automatic wait_sig(input string tag, input int budget, input int which);
        logic got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge axis_clk);
            if ((which == 0 && awvalid) || (which == 1 && ss_tvalid)) got = 1'b1;
        end
        chk({tag, "_seen"}, 32'(got), 1);
    endtask

    initial begin
        axis_rst_n = 1'b0; cmd_start = 1'b0; cmd_len = '0;
        repeat (2) @(negedge axis_clk);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready, res_valid}), 0);
        chk("rst_status", 32'({busy, done, err}), 0);
        chk("rst_addr", 32'({awaddr, araddr}), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_idx", 32'({coef_idx, smp_idx, res_idx}), 0);
        chk("rst_res_data", res_data, 0);
        @(posedge axis_clk); #1 axis_rst_n = 1'b1;

        // basic run, N=4, all ready
        clr(4, 6);
        start(4);
        @(negedge axis_clk);
        chk("t2_busy", 32'(busy), 1);
        wait_done("t2", 2000, 1'b0);
        chk("t2_aw_count", aw_q.size(), 13);
        chk("t2_w_count", w_q.size(), 13);
        chk("t2_len_addr", aw_q[0], 32'h10);
        chk("t2_len_data", w_q[0], 4);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t2_tap%0d_addr", i), aw_q[1 + i], 32'h20 + 4 * i);
            chk($sformatf("t2_tap%0d_data", i), w_q[1 + i], 32'hC000 + 17 * i);
        end
        chk("t2_start_addr", aw_q[12], 0);
        chk("t2_start_data", w_q[12], 1);
        chk("t2_ss_beats", ss_n, 4);
        chk("t2_tlast_count", tlast_n, 1);
        chk("t2_ss_err", ss_err, 0);
        chk("t2_res_count", res_n, 4);
        chk("t2_res_err", res_err, 0);
        chk("t2_sm_no_extra", sm_acc, 4);
        chk("t2_reads", ar_n, 1);

        // split AW/W handshakes
        aw_delay = 3;
        clr(2, 2);
        start(2);
        wait_sig("t3_aw", 50, 0);
        chk("t3_c0_wvalid", 32'(wvalid), 1);
        @(negedge axis_clk);
        chk("t3_c1_wvalid", 32'(wvalid), 0);
        chk("t3_c1_awvalid", 32'(awvalid), 1);
        @(negedge axis_clk);
        @(negedge axis_clk);
        chk("t3_c3_awvalid", 32'(awvalid), 1);
        chk("t3_c3_awaddr", 32'(awaddr), 32'h10);
        @(negedge axis_clk);
        chk("t3_c4_awvalid", 32'(awvalid), 0);
        wait_done("t3", 2000, 1'b0);
        chk("t3_order", order_err, 0);
        chk("t3_stable", stab_err, 0);
        chk("t3_aw_count", aw_q.size(), 13);
        chk("t3_start_data", w_q[12], 1);
        aw_delay = 0;

        // backpressure, N=600
        ss_toggle = 1'b1; sm_bursty = 1'b1;
        clr(600, 600);
        start(10'd600);
        wait_done("t4", 6000, 1'b0);
        chk("t4_ss_beats", ss_n, 600);
        chk("t4_ss_err", ss_err, 0);
        chk("t4_tlast_count", tlast_n, 1);
        chk("t4_res_count", res_n, 600);
        chk("t4_res_err", res_err, 0);
        chk("t4_len_data", w_q[0], 600);
        ss_toggle = 1'b0; sm_bursty = 1'b0;

        // polling: done on 5th read, never done, done on the last allowed read
        done_on_read = 5;
        clr(1, 1);
        start(1);
        wait_done("t5a", 500, 1'b0);
        chk("t5a_reads", ar_n, 5);
        done_on_read = 1000;
        clr(1, 1);
        start(1);
        wait_done("t5b", 500, 1'b1);
        chk("t5b_reads", ar_n, PM);
        done_on_read = PM;
        clr(1, 1);
        start(1);
        wait_done("t5c", 500, 1'b0);
        chk("t5c_reads", ar_n, PM);
        done_on_read = 1;

        // zero length and ignored restart while busy
        clr(0, 0);
        start(0);
        @(negedge axis_clk);
        chk("t6_zero_done", 32'(done), 1);
        chk("t6_zero_err", 32'(err), 1);
        chk("t6_zero_busy", 32'(busy), 0);
        repeat (10) @(negedge axis_clk);
        chk("t6_zero_traffic", aw_q.size() + ar_n + ss_n, 0);
        chk("t6_zero_one_pulse", done_n, 1);
        clr(3, 3);
        start(3);
        repeat (5) @(posedge axis_clk);
        #1 cmd_len = 10'd7; cmd_start = 1'b1;
        @(posedge axis_clk); #1 cmd_start = 1'b0;
        wait_done("t6", 2000, 1'b0);
        chk("t6_len_kept", w_q[0], 3);
        chk("t6_ss_beats", ss_n, 3);
        repeat (40) @(negedge axis_clk);
        chk("t6_single_run", done_n, 1);
        chk("t6_aw_count", aw_q.size(), 13);

        // async reset mid-stream
        ss_toggle = 1'b1;
        clr(50, 50);
        start(10'd50);
        wait_sig("t1_stream", 300, 1);
        axis_rst_n = 1'b0;
        #1;
        chk("t1_valids", 32'({awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready}), 0);
        chk("t1_busy", 32'(busy), 0);
        repeat (2) @(posedge axis_clk);
        #1 axis_rst_n = 1'b1;
        @(negedge axis_clk);
        chk("t1_idle_after", 32'({busy, ss_tvalid, awvalid}), 0);
        ss_toggle = 1'b0;
        clr(1, 1);
        start(1);
        wait_done("t1_rerun", 500, 1'b0);
        chk("t1_rerun_len", w_q[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
